// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word/round types, schedule sigma functions and
// the round-constant fetch FSM encoding. Used by every SHA-256 block.
package sha256_pkg;

  localparam int WORD_W    = 32;                  // SHA-256 word width (fixed)
  localparam int NROUNDS   = 64;                  // rounds per block = K ROM depth
  localparam int RND_W     = $clog2(NROUNDS);     // round index width
  localparam int WIN_DEPTH = 16;                  // message schedule window depth
  localparam int BLK_W     = WIN_DEPTH * WORD_W;  // one 512-bit message block

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [RND_W-1:0]  round_t;

  localparam round_t LAST_ROUND = round_t'(NROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // Rotate right by n bits (0 < n < WORD_W).
  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // Small sigma 0 of the message schedule.
  function automatic word_t sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  // Small sigma 1 of the message schedule.
  function automatic word_t sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_kw_fetch_if.sv
// Block-in / K-ROM read / KW-out signal bundle of the KW fetch unit.
// master = the fetch unit, slave = its environment (block source, ROM, core).
interface sha256_kw_fetch_if;
  import sha256_pkg::*;

  // message block input
  logic               blk_valid;
  logic               blk_ready;
  logic [BLK_W-1:0]   blk_data;

  // K ROM read port (registered ROM output)
  logic               rom_rd;
  round_t             rom_addr;
  word_t              rom_k;

  // KW stream to the compression core
  logic               kw_valid;
  logic               kw_ready;
  word_t              kw_data;
  round_t             kw_round;
  logic               kw_last;

  // status
  logic               busy;

  modport master (
    input  blk_valid, blk_data, rom_k, kw_ready,
    output blk_ready, rom_rd, rom_addr,
           kw_valid, kw_data, kw_round, kw_last, busy
  );

  modport slave (
    output blk_valid, blk_data, rom_k, kw_ready,
    input  blk_ready, rom_rd, rom_addr,
           kw_valid, kw_data, kw_round, kw_last, busy
  );

endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: a 16-word sliding window over W_t.
// win[0] is always W_t for the round about to be issued; each shift appends
// W_{t+16} computed from the current window.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,      // capture a new block (W0..W15)
  input  logic             shift,     // advance window by one round
  input  logic [BLK_W-1:0] blk_data,
  output word_t            w_head     // W_t of the current round
);

  word_t win [WIN_DEPTH];
  word_t w_next;

  // W_{t+16} = sigma1(W_{t+14}) + W_{t+9} + sigma0(W_{t+1}) + W_t, mod 2^32
  // NOTE: combinational logic uses blocking '=' so the result is read back
  // within the same evaluation, as plain wires would be.
  always_comb begin
    w_next = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
  end

  // Window register: load on block accept, otherwise shift per issued round.
  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge window; with '=' the shift would ripple through in one edge.
  // NOTE: the window is a flop array, not a RAM macro, so it takes the async
  // clear like any other register and a reset leaves no stale block data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN_DEPTH; i++) win[i] <= '0;
    end else if (load) begin
      // big-endian: W0 sits in the top word of the block
      for (int i = 0; i < WIN_DEPTH; i++)
        win[i] <= blk_data[(WIN_DEPTH-1-i)*WORD_W +: WORD_W];
    end else if (shift) begin
      for (int i = 0; i < WIN_DEPTH-1; i++) win[i] <= win[i+1];
      win[WIN_DEPTH-1] <= w_next;
    end
  end

  assign w_head = win[0];

endmodule

// File: rtl/sha256_kw_fetch.sv
// SHA-256 KW fetch: accepts a 512-bit block, expands the message schedule,
// reads K_t from the external registered round-constant ROM and streams
// KW_t = K_t + W_t to the compression core over valid/ready.
//
// Pipeline: issue (ROM read of K_t, W_t captured into p1) -> output register.
// Both stages move together on 'advance'; when the output is stalled the ROM
// is not read, so its output register keeps K for the word parked in p1.
module sha256_kw_fetch
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  sha256_kw_fetch_if.master  bus
);

  state_t state_q, state_d;
  round_t t_q;             // next round to issue to the ROM

  logic   advance;         // output register may take a new value this edge
  logic   accept;          // block handshake this edge
  logic   blk_ready;
  logic   rom_rd;
  logic   busy;

  word_t  w_head;          // W_t for round t_q

  // issue stage: W and round index waiting for K from the ROM
  logic   p1_valid;
  word_t  p1_w;
  round_t p1_t;

  // output register
  logic   kw_valid_q;
  word_t  kw_data_q;
  round_t kw_round_q;
  logic   kw_last_q;

  assign advance = !kw_valid_q || bus.kw_ready;
  assign accept  = blk_ready && bus.blk_valid;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.blk_valid)                           state_d = RUN;
      RUN:     if (advance && t_q == LAST_ROUND)            state_d = DRAIN;
      DRAIN:   if (kw_valid_q && bus.kw_ready && kw_last_q) state_d = IDLE;
      default:                                              state_d = IDLE;
    endcase
  end

  // FSM outputs: block handshake, ROM read strobe, busy flag
  always_comb begin
    blk_ready = (state_q == IDLE);
    rom_rd    = (state_q == RUN) && advance;
    busy      = (state_q != IDLE);
  end

  // Round issue counter: restarts on accept, steps on every ROM read
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         t_q <= '0;
    else if (accept) t_q <= '0;
    else if (rom_rd) t_q <= t_q + round_t'(1);
  end

  // Issue stage: park W_t and t beside the ROM read of K_t
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid <= 1'b0;
      p1_w     <= '0;
      p1_t     <= '0;
    end else if (advance) begin
      p1_valid <= rom_rd;
      if (rom_rd) begin
        p1_w <= w_head;
        p1_t <= t_q;
      end
    end
  end

  // Output register: KW = K + W, held unchanged while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kw_valid_q <= 1'b0;
      kw_data_q  <= '0;
      kw_round_q <= '0;
      kw_last_q  <= 1'b0;
    end else if (advance) begin
      kw_valid_q <= p1_valid;
      kw_data_q  <= bus.rom_k + p1_w;
      kw_round_q <= p1_t;
      kw_last_q  <= p1_valid && (p1_t == LAST_ROUND);
    end
  end

  sha256_msg_sched u_msg_sched (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (rom_rd),
    .blk_data (bus.blk_data),
    .w_head   (w_head)
  );

  assign bus.blk_ready = blk_ready;
  assign bus.rom_rd    = rom_rd;
  assign bus.rom_addr  = t_q;
  assign bus.kw_valid  = kw_valid_q;
  assign bus.kw_data   = kw_data_q;
  assign bus.kw_round  = kw_round_q;
  assign bus.kw_last   = kw_last_q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_sha256_kw_fetch.sv
// Self-checking bench for sha256_kw_fetch with a registered K ROM model.
module tb_sha256_kw_fetch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha256_kw_fetch_if bus ();

  sha256_kw_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] ABC_BLK  = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [511:0] ONES_BLK = {512{1'b1}};
  // {blk_ready, busy, rom_rd, kw_valid, kw_last, rom_addr, kw_round, kw_data}
  localparam logic [48:0]  RESET_STATUS = {1'b1, 4'b0000, 6'd0, 6'd0, 32'd0};

  // registered ROM: output updates only on a read, holds otherwise
  logic [31:0] rom_q = '0;
  always @(posedge clk) if (bus.rom_rd) rom_q <= K_TAB[bus.rom_addr];
  assign bus.rom_k = rom_q;

  int n_checks = 0;
  int n_pass   = 0;

  // expected KW sequence and captured beats
  logic [31:0] exp_kw    [64];
  logic [31:0] got_data  [64];
  logic [5:0]  got_round [64];
  logic        got_last  [64];
  int          first_bad;

  // per-block observations filled by collect()
  int   n_beats, first_k, last_k, last_count, n_stalls;
  int   stall_rd_viol, stall_hold_viol;
  int   busy_low_idle, busy_low_run, ready_in_run, stray_valid;
  logic rd_at_1;
  logic [5:0] addr_at_1;
  bit   timeout;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // software schedule model: exp_kw[t] = K[t] + W[t]
  task automatic build_expected(input logic [511:0] blk);
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) exp_kw[t] = K_TAB[t] + w[t];
  endtask

  function automatic int seq_errors();
    int errs;
    errs = 0;
    first_bad = 0;
    for (int t = 0; t < 64; t++) begin
      if (got_data[t] !== exp_kw[t] || got_round[t] !== 6'(t) ||
          got_last[t] !== (t == 63)) begin
        if (errs == 0) first_bad = t;
        errs++;
      end
    end
    return errs;
  endfunction

  function automatic logic [48:0] status();
    return {bus.blk_ready, bus.busy, bus.rom_rd, bus.kw_valid, bus.kw_last,
            bus.rom_addr, bus.kw_round, bus.kw_data};
  endfunction

  // Offer blk, then capture KW beats until the last handshake.
  // Starts and ends 1 time unit after a rising edge; with abort_round >= 0
  // returns at the falling edge where that round is seen handshaking.
  task automatic collect(input logic [511:0] blk, input logic [511:0] next_blk,
                         input bit keep_valid, input bit rand_ready,
                         input int abort_round);
    bit accepted, stalled, done;
    logic [31:0] s_data;
    logic [5:0]  s_round;
    logic        s_last;
    n_beats = 0; first_k = -1; last_k = -1; last_count = 0; n_stalls = 0;
    stall_rd_viol = 0; stall_hold_viol = 0; busy_low_idle = 0;
    busy_low_run = 0; ready_in_run = 0; stray_valid = 0; timeout = 0;
    rd_at_1 = 1'b0; addr_at_1 = '1;
    s_data = '0; s_round = '0; s_last = 1'b0;
    for (int i = 0; i < 64; i++) begin
      got_data[i] = '0; got_round[i] = '0; got_last[i] = 1'b0;
    end
    bus.blk_valid = 1'b1;
    bus.blk_data  = blk;
    accepted = 0;
    for (int c = 0; c < 16 && !accepted; c++) begin
      @(negedge clk);
      if (!bus.busy) busy_low_idle++;
      if (bus.kw_valid) stray_valid++;
      if (bus.blk_ready) accepted = 1;
      @(posedge clk); #1;
    end
    if (!accepted) begin
      timeout = 1;
      bus.blk_valid = 1'b0;
      return;
    end
    bus.blk_valid = keep_valid;
    bus.blk_data  = next_blk;
    stalled = 0;
    done = 0;
    for (int k = 1; k <= 400 && !done; k++) begin
      bus.kw_ready = rand_ready ? (((k * 7 + 3) % 5) > 1) : 1'b1;
      @(negedge clk);
      if (k == 1) begin
        rd_at_1   = bus.rom_rd;
        addr_at_1 = bus.rom_addr;
      end
      if (!bus.busy) busy_low_run++;
      if (bus.blk_ready) ready_in_run++;
      if (stalled && (!bus.kw_valid || bus.kw_data !== s_data ||
                      bus.kw_round !== s_round || bus.kw_last !== s_last))
        stall_hold_viol++;
      stalled = 0;
      if (bus.kw_valid && !bus.kw_ready) begin
        n_stalls++;
        stalled = 1;
        s_data  = bus.kw_data;
        s_round = bus.kw_round;
        s_last  = bus.kw_last;
        if (bus.rom_rd) stall_rd_viol++;
      end
      if (bus.kw_valid && bus.kw_ready) begin
        if (first_k < 0) first_k = k;
        if (n_beats < 64) begin
          got_data[n_beats]  = bus.kw_data;
          got_round[n_beats] = bus.kw_round;
          got_last[n_beats]  = bus.kw_last;
        end
        n_beats++;
        if (bus.kw_last) begin
          last_count++;
          last_k = k;
          done = 1;
        end
        if (int'(bus.kw_round) == abort_round) return;
      end
      @(posedge clk); #1;
    end
    if (!done) timeout = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.kw_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (status() !== RESET_STATUS)
      $display("FAIL reset_state: got %013h want %013h", status(), RESET_STATUS);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_abc();
    int errs;
    build_expected(ABC_BLK);
    collect(ABC_BLK, '0, 1'b0, 1'b0, -1);
    errs = seq_errors();
    n_checks++;
    if (timeout || n_beats !== 64)
      $display("FAIL abc_beats: got %0d beats (timeout=%0d) want 64", n_beats, timeout);
    else n_pass++;
    n_checks++;
    if (rd_at_1 !== 1'b1 || addr_at_1 !== 6'd0)
      $display("FAIL abc_first_read: got rd=%0b addr=%0d want rd=1 addr=0", rd_at_1, addr_at_1);
    else n_pass++;
    n_checks++;
    if (first_k - 1 !== 2)
      $display("FAIL abc_latency: got kw_valid at edge %0d want 2", first_k - 1);
    else n_pass++;
    n_checks++;
    if (last_k !== 66)
      $display("FAIL abc_throughput: got last handshake at edge %0d want 66", last_k);
    else n_pass++;
    n_checks++;
    if (got_data[0] !== 32'hA3EC9318)
      $display("FAIL abc_round0: got %08h want a3ec9318", got_data[0]);
    else n_pass++;
    n_checks++;
    if (got_data[15] !== 32'hC19BF18C)
      $display("FAIL abc_round15: got %08h want c19bf18c", got_data[15]);
    else n_pass++;
    n_checks++;
    if (got_data[16] !== 32'h45FDCD41)
      $display("FAIL abc_round16: got %08h want 45fdcd41", got_data[16]);
    else n_pass++;
    n_checks++;
    if (errs !== 0)
      $display("FAIL abc_sequence: %0d bad beats, first round %0d got %08h/%0d/%0b want %08h",
               errs, first_bad, got_data[first_bad], got_round[first_bad],
               got_last[first_bad], exp_kw[first_bad]);
    else n_pass++;
    n_checks++;
    if (busy_low_run !== 0)
      $display("FAIL abc_busy: got %0d busy-low cycles mid-block want 0", busy_low_run);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int errs;
    build_expected(ABC_BLK);
    collect(ABC_BLK, '0, 1'b0, 1'b1, -1);
    errs = seq_errors();
    n_checks++;
    if (timeout || n_beats !== 64)
      $display("FAIL bp_beats: got %0d beats (timeout=%0d) want 64", n_beats, timeout);
    else n_pass++;
    n_checks++;
    if (errs !== 0)
      $display("FAIL bp_sequence: %0d bad beats, first round %0d got %08h want %08h",
               errs, first_bad, got_data[first_bad], exp_kw[first_bad]);
    else n_pass++;
    n_checks++;
    if (n_stalls == 0)
      $display("FAIL bp_stalls: got %0d stalled cycles want >0", n_stalls);
    else n_pass++;
    n_checks++;
    if (stall_rd_viol !== 0)
      $display("FAIL bp_rom_rd: got %0d reads during stall want 0", stall_rd_viol);
    else n_pass++;
    n_checks++;
    if (stall_hold_viol !== 0)
      $display("FAIL bp_hold: got %0d output changes during stall want 0", stall_hold_viol);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int errs;
    build_expected(ABC_BLK);
    collect(ABC_BLK, ONES_BLK, 1'b1, 1'b0, -1);
    errs = seq_errors();
    n_checks++;
    if (timeout || n_beats !== 64 || errs !== 0)
      $display("FAIL b2b_first_block: got %0d beats, %0d bad want 64, 0", n_beats, errs);
    else n_pass++;
    n_checks++;
    if (ready_in_run !== 0)
      $display("FAIL b2b_overlap: got blk_ready high %0d cycles mid-block want 0", ready_in_run);
    else n_pass++;
    build_expected(ONES_BLK);
    collect(ONES_BLK, '0, 1'b0, 1'b0, -1);
    errs = seq_errors();
    n_checks++;
    if (busy_low_idle !== 1)
      $display("FAIL b2b_idle_gap: got %0d busy-low cycles want 1", busy_low_idle);
    else n_pass++;
    n_checks++;
    if (timeout || n_beats !== 64 || errs !== 0)
      $display("FAIL b2b_second_block: got %0d beats, %0d bad, first round %0d got %08h want %08h",
               n_beats, errs, first_bad, got_data[first_bad], exp_kw[first_bad]);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [511:0] ramp;
    int errs;
    build_expected(ABC_BLK);
    collect(ABC_BLK, '0, 1'b0, 1'b0, 30);
    n_checks++;
    if (n_beats !== 31)
      $display("FAIL midrst_progress: got %0d beats before reset want 31", n_beats);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (status() !== RESET_STATUS)
      $display("FAIL midrst_async: got %013h want %013h", status(), RESET_STATUS);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) ramp[511 - 32*i -: 32] = 32'(32'h9e3779b9 * (i + 1));
    build_expected(ramp);
    collect(ramp, '0, 1'b0, 1'b0, -1);
    errs = seq_errors();
    n_checks++;
    if (stray_valid !== 0)
      $display("FAIL midrst_stray: got %0d kw_valid cycles before restart want 0", stray_valid);
    else n_pass++;
    n_checks++;
    if (timeout || n_beats !== 64 || got_round[0] !== 6'd0)
      $display("FAIL midrst_restart: got %0d beats, first round %0d want 64, 0", n_beats, got_round[0]);
    else n_pass++;
    n_checks++;
    if (errs !== 0)
      $display("FAIL midrst_sequence: %0d bad beats, first round %0d got %08h want %08h",
               errs, first_bad, got_data[first_bad], exp_kw[first_bad]);
    else n_pass++;
  endtask

  task automatic test_all_ones();
    int errs;
    build_expected(ONES_BLK);
    collect(ONES_BLK, '0, 1'b0, 1'b0, -1);
    errs = seq_errors();
    n_checks++;
    if (got_data[0] !== 32'h428A2F97)
      $display("FAIL ones_round0_wrap: got %08h want 428a2f97", got_data[0]);
    else n_pass++;
    n_checks++;
    if (timeout || n_beats !== 64 || errs !== 0)
      $display("FAIL ones_sequence: %0d beats, %0d bad, first round %0d got %08h want %08h",
               n_beats, errs, first_bad, got_data[first_bad], exp_kw[first_bad]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_all_ones();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
